// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: round-robin sharing of one adder between two requesters with a one-entry response slot.
// Optional ADDER_SHARE_OVF_EN adds registered carry-out and signed-overflow response ports.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef ADDER_SHARE_OVF_EN
    output logic             cout,
`endif
    output logic [WIDTH-1:0] sum
);
`ifdef ADDER_SHARE_OVF_EN
    assign {cout, sum} = {1'b0, a} + {1'b0, b};
`else
    assign sum = a + b;
`endif
endmodule

module adder_share_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
`ifdef ADDER_SHARE_OVF_EN
    output logic             resp_cout,
    output logic             resp_ovf,
`endif
    output logic [WIDTH-1:0] resp_sum,
    input  logic             resp_ready
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q;
    logic             resp_id_q;
    logic [WIDTH-1:0] resp_sum_q;
    logic             grant, any_req, can_accept, xfer;
    logic [WIDTH-1:0] op_a, op_b, add_sum;

    // Contest goes to the port that did not win last; a lone requester always wins.
    assign any_req    = req0_valid | req1_valid;
    assign grant      = (req0_valid & req1_valid) ? ~last_grant_q : req1_valid;
    assign can_accept = rst_n & ((state_q == EMPTY) | resp_ready);
    assign req0_ready = can_accept & any_req & ~grant;
    assign req1_ready = can_accept & any_req & grant;
    assign xfer       = req0_ready | req1_ready;
    assign op_a       = grant ? req1_a : req0_a;
    assign op_b       = grant ? req1_b : req0_b;

`ifdef ADDER_SHARE_OVF_EN
    logic add_cout, add_ovf, resp_cout_q, resp_ovf_q;
    assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) & (add_sum[WIDTH-1] != op_a[WIDTH-1]);
    adder #(.WIDTH(WIDTH)) u_adder (.a(op_a), .b(op_b), .cout(add_cout), .sum(add_sum));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_cout_q <= 1'b0;
            resp_ovf_q  <= 1'b0;
        end else if (xfer) begin
            resp_cout_q <= add_cout;
            resp_ovf_q  <= add_ovf;
        end
    end
    assign resp_cout = resp_cout_q;
    assign resp_ovf  = resp_ovf_q;
`else
    adder #(.WIDTH(WIDTH)) u_adder (.a(op_a), .b(op_b), .sum(add_sum));
`endif

    always_comb begin
        state_d = state_q;
        if (xfer)
            state_d = FULL;
        else if (state_q == FULL && resp_ready)
            state_d = EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            last_grant_q <= 1'b1;
            resp_id_q    <= 1'b0;
            resp_sum_q   <= '0;
        end else begin
            state_q <= state_d;
            if (xfer) begin
                last_grant_q <= grant;
                resp_id_q    <= grant;
                resp_sum_q   <= add_sum;
            end
        end
    end

    assign resp_valid = (state_q == FULL);
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: directed checks of arbitration, latency, backpressure, fairness and reset.
module tb_adder_share_ctrl;
    logic        clk = 0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b, resp_sum;
    logic        resp_valid, resp_id, resp_ready;
`ifdef ADDER_SHARE_OVF_EN
    logic        resp_cout, resp_ovf;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_share_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp_valid(resp_valid), .resp_id(resp_id),
`ifdef ADDER_SHARE_OVF_EN
        .resp_cout(resp_cout), .resp_ovf(resp_ovf),
`endif
        .resp_sum(resp_sum), .resp_ready(resp_ready)
    );

    task automatic step;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 0; resp_ready = 1;
        req0_valid = 1; req0_a = 1; req0_b = 1;
        req1_valid = 1; req1_a = 2; req1_b = 2;
        step(); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
        checks++; if (resp_sum !== 32'h0) begin errors++; $display("FAIL reset_sum got %h exp 0", resp_sum); end
        checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready}); end
        req0_valid = 0; req1_valid = 0;
        rst_n = 1;
        step(); step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_empty got %b exp 0", resp_valid); end
    endtask

    task automatic test_contest;
        req0_valid = 1; req0_a = 32'hFFFF0000; req0_b = 32'h0000FFFF;
        req1_valid = 1; req1_a = 32'hFFFFFFFF; req1_b = 32'h1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL contest_first_ready got %b exp 10", {req0_ready, req1_ready}); end
        step();
        checks++; if ({resp_valid, resp_id, resp_sum} !== {1'b1, 1'b0, 32'hFFFFFFFF}) begin errors++; $display("FAIL contest_r0 got %b %b %h exp 1 0 ffffffff", resp_valid, resp_id, resp_sum); end
        req0_valid = 0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL contest_second_ready got %b exp 01", {req0_ready, req1_ready}); end
        step();
        checks++; if ({resp_valid, resp_id, resp_sum} !== {1'b1, 1'b1, 32'h0}) begin errors++; $display("FAIL contest_r1 got %b %b %h exp 1 1 00000000", resp_valid, resp_id, resp_sum); end
`ifdef ADDER_SHARE_OVF_EN
        checks++; if ({resp_cout, resp_ovf} !== 2'b10) begin errors++; $display("FAIL contest_cout_ovf got %b exp 10", {resp_cout, resp_ovf}); end
`endif
        req0_valid = 1; req0_a = 32'h3; req0_b = 32'h4;
        req1_a = 32'h10; req1_b = 32'h20;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL contest_again_ready got %b exp 10", {req0_ready, req1_ready}); end
        step();
        checks++; if ({resp_id, resp_sum} !== {1'b0, 32'h7}) begin errors++; $display("FAIL contest_again got %b %h exp 0 00000007", resp_id, resp_sum); end
        req0_valid = 0; req1_valid = 0;
        step(); step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL contest_drain got %b exp 0", resp_valid); end
    endtask

    task automatic test_single;
        logic [31:0] va [3] = '{32'h1, 32'h4, 32'hFF00};
        logic [31:0] vb [3] = '{32'h1, 32'h8, 32'h00FF};
        logic [31:0] vs [3] = '{32'h2, 32'hC, 32'h0000FFFF};
        resp_ready = 1;
        for (int i = 0; i < 3; i++) begin
            req0_valid = 1; req0_a = va[i]; req0_b = vb[i];
            #1;
            checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_ready[%0d] got %b exp 10", i, {req0_ready, req1_ready}); end
            step();
            checks++; if ({resp_valid, resp_id, resp_sum} !== {1'b1, 1'b0, vs[i]}) begin errors++; $display("FAIL single[%0d] got %b %b %h exp 1 0 %h", i, resp_valid, resp_id, resp_sum, vs[i]); end
        end
        req0_valid = 0;
        step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", resp_valid); end
    endtask

    task automatic test_backpressure;
        resp_ready = 0;
        req0_valid = 1; req0_a = 32'd10; req0_b = 32'd5;
        #1;
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", req0_ready); end
        step();
        req0_valid = 0;
        req1_valid = 1; req1_a = 32'd100; req1_b = 32'd200;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 00", i, {req0_ready, req1_ready}); end
            checks++; if ({resp_valid, resp_id, resp_sum} !== {1'b1, 1'b0, 32'd15}) begin errors++; $display("FAIL bp_hold[%0d] got %b %b %h exp 1 0 0000000f", i, resp_valid, resp_id, resp_sum); end
            step();
        end
        resp_ready = 1;
        #1;
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", req1_ready); end
        step();
        checks++; if ({resp_valid, resp_id, resp_sum} !== {1'b1, 1'b1, 32'd300}) begin errors++; $display("FAIL bp_nobubble got %b %b %h exp 1 1 0000012c", resp_valid, resp_id, resp_sum); end
        req1_valid = 0;
        step(); step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", resp_valid); end
    endtask

    task automatic test_fairness;
        resp_ready = 1;
        req0_valid = 1; req0_a = 32'd7; req0_b = 32'd1;
        req1_valid = 1; req1_a = 32'd7; req1_b = 32'd2;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if ({resp_valid, resp_id, resp_sum} !== {1'b1, k[0], (k[0] ? 32'd9 : 32'd8)}) begin
                errors++; $display("FAIL fair[%0d] got %b %b %h exp 1 %b %h", k, resp_valid, resp_id, resp_sum, k[0], k[0] ? 32'd9 : 32'd8);
            end
        end
        req0_valid = 0; req1_valid = 0;
        step(); step();
    endtask

    task automatic test_midop_reset;
        resp_ready = 1;
        req0_valid = 1; req0_a = 32'd4; req0_b = 32'd8;
        step();
        req0_valid = 0; resp_ready = 0;
        checks++; if ({resp_valid, resp_sum} !== {1'b1, 32'd12}) begin errors++; $display("FAIL midop_full got %b %h exp 1 0000000c", resp_valid, resp_sum); end
        #2 rst_n = 0;
        #1;
        checks++; if ({resp_valid, resp_sum} !== {1'b0, 32'h0}) begin errors++; $display("FAIL midop_reset got %b %h exp 0 00000000", resp_valid, resp_sum); end
        step();
        rst_n = 1; resp_ready = 1;
        step(); step();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL midop_stale got %b exp 0", resp_valid); end
    endtask

    initial begin
        test_reset();
        test_contest();
        test_single();
        test_backpressure();
        test_fairness();
        test_midop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
